// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED frame sequencer and the display top level:
// default command bytes, default frame geometry, the sequencer state
// encoding and a helper giving the number of bytes in one frame.
// No ports (package).
package led_pkg;

    localparam int         DEF_COLUMNS     = 16;
    localparam logic [7:0] DEF_CMD_DATA    = 8'h44;
    localparam logic [7:0] DEF_CMD_ADDR    = 8'hC0;
    localparam logic [7:0] DEF_CMD_DISP    = 8'h88;
    localparam int         DEF_ACK_TIMEOUT = 15;

    // Byte index is 6 bits, so a frame is limited to 64 bytes (31 columns).
    localparam int INDEX_W = 6;
    localparam int COL_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_NEXT
    } seq_state_t;

    // One data command, an address/data pair per column, one display command.
    function automatic int frame_bytes(input int columns);
        return 2 * columns + 2;
    endfunction

endpackage

// File: rtl/led_frame_store.sv
// led_frame_store
// Column register file plus a shadow copy used while a frame is sent.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en/addr/data     column write; addresses >= COLUMNS are dropped
//   snap                copy the store into the shadow (includes a write on
//                       the same cycle)
//   rd_col / rd_data    combinational read of the shadow copy
module led_frame_store
    import led_pkg::*;
#(
    parameter int COLUMNS = DEF_COLUMNS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             snap,
    input  logic [COL_W-1:0] rd_col,
    output logic [7:0]       rd_data
);

    logic [7:0] store  [COLUMNS];
    logic [7:0] shadow [COLUMNS];

    // The shadow takes the incoming write directly so a write issued on the
    // refresh cycle is part of the frame that refresh starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COLUMNS; i++) begin
                store[i]  <= 8'h00;
                shadow[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < COLUMNS; i++) begin
                if (wr_en && int'(wr_addr) == i)
                    store[i] <= wr_data;
                if (snap)
                    shadow[i] <= (wr_en && int'(wr_addr) == i) ? wr_data : store[i];
            end
        end
    end

    // Compare-based lookup keeps out-of-range column numbers harmless.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < COLUMNS; i++)
            if (int'(rd_col) == i)
                rd_data = shadow[i];
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
// Sends a full LED frame (data command, address/data pair per column,
// display command with brightness) one byte at a time to a downstream
// byte serializer using a valid/busy handshake.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   wr_en/addr/data      column byte write into the frame store
//   refresh, brightness  frame request; brightness latched when accepted
//   frame_busy           high while a frame is being sent
//   err                  sticky acknowledge-timeout flag
//   px_valid, px_value   byte strobe and byte to the serializer
//   px_busy              serializer busy
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int         COLUMNS     = DEF_COLUMNS,
    parameter logic [7:0] CMD_DATA    = DEF_CMD_DATA,
    parameter logic [7:0] CMD_ADDR    = DEF_CMD_ADDR,
    parameter logic [7:0] CMD_DISP    = DEF_CMD_DISP,
    parameter int         ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic [2:0] brightness,
    output logic       frame_busy,
    output logic       err,
    output logic       px_valid,
    output logic [7:0] px_value,
    input  logic       px_busy
);

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(frame_bytes(COLUMNS) - 1);
    localparam logic [7:0]         ACK_LAST = 8'(ACK_TIMEOUT - 1);

    seq_state_t         state, next_state;
    logic [INDEX_W-1:0] index, next_index;
    logic [7:0]         ack_count;
    logic [2:0]         bright_q;
    logic               pending;
    logic               start, timeout, load_value, last_done;
    logic [COL_W-1:0]   rd_col;
    logic [7:0]         rd_data, next_value;

    led_frame_store #(
        .COLUMNS (COLUMNS)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .snap    (start),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    // Byte for a given index: 0 is the data command, the last is the display
    // command, odd indices are addresses and even ones column data.
    always_comb begin
        rd_col = COL_W'((next_index - INDEX_W'(2)) >> 1);
        if (next_index == '0)
            next_value = CMD_DATA;
        else if (next_index == LAST_IDX)
            next_value = CMD_DISP | {5'b00000, bright_q};
        else if (next_index[0])
            next_value = CMD_ADDR + 8'((next_index - INDEX_W'(1)) >> 1);
        else
            next_value = rd_data;
    end

    // Next-state logic. A new frame only starts from IDLE with the
    // serializer quiet, since it keeps running across our reset.
    always_comb begin
        next_state = state;
        next_index = index;
        start      = 1'b0;
        timeout    = 1'b0;
        load_value = 1'b0;
        last_done  = 1'b0;
        px_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((refresh || pending) && !px_busy) begin
                    start      = 1'b1;
                    next_index = '0;
                    load_value = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                px_valid   = 1'b1;
                next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (px_busy) begin
                    next_state = ST_WAIT_DONE;
                end else if (ack_count == ACK_LAST) begin
                    timeout    = 1'b1;
                    load_value = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (!px_busy) begin
                    last_done  = (index == LAST_IDX);
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (index == LAST_IDX) begin
                    next_state = ST_IDLE;
                end else begin
                    next_index = index + INDEX_W'(1);
                    load_value = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered state. Any refresh not accepted immediately becomes one
    // pending request; the start of a frame consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            index      <= '0;
            ack_count  <= 8'h00;
            bright_q   <= 3'd0;
            pending    <= 1'b0;
            frame_busy <= 1'b0;
            err        <= 1'b0;
            px_value   <= 8'h00;
        end else begin
            state <= next_state;
            index <= next_index;
            if (state == ST_ISSUE)
                ack_count <= 8'h00;
            else if (state == ST_WAIT_ACK)
                ack_count <= ack_count + 8'd1;
            if (start) begin
                bright_q   <= brightness;
                frame_busy <= 1'b1;
            end else if (last_done) begin
                frame_busy <= 1'b0;
            end
            if (start)
                pending <= 1'b0;
            else if (refresh)
                pending <= 1'b1;
            if (timeout)
                err <= 1'b1;
            if (load_value)
                px_value <= next_value;
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer
// Self-checking bench: a 16-column instance with a configurable downstream
// serializer model, and an 8-column instance with a fixed quick model.
// Expected frames are built from a behavioural copy of the frame store.
module tb_led_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, refresh;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] brightness;
    logic       frame_busy, err, px_valid;
    logic [7:0] px_value;
    logic       px_busy = 1'b0;

    logic       wr_en_b, refresh_b;
    logic [3:0] wr_addr_b;
    logic [7:0] wr_data_b;
    logic [2:0] brightness_b;
    logic       frame_busy_b, err_b, px_valid_b;
    logic [7:0] px_value_b;
    logic       px_busy_b = 1'b0;

    led_frame_sequencer dut (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr),
        .wr_data (wr_data), .refresh (refresh), .brightness (brightness),
        .frame_busy (frame_busy), .err (err), .px_valid (px_valid),
        .px_value (px_value), .px_busy (px_busy)
    );

    led_frame_sequencer #(.COLUMNS (8)) dut_b (
        .clk (clk), .rst (rst), .wr_en (wr_en_b), .wr_addr (wr_addr_b),
        .wr_data (wr_data_b), .refresh (refresh_b), .brightness (brightness_b),
        .frame_busy (frame_busy_b), .err (err_b), .px_valid (px_valid_b),
        .px_value (px_value_b), .px_busy (px_busy_b)
    );

    // Downstream model: mode 0 normal, 1 never busy, 2 busy forced high.
    int ds_mode = 0, ds_delay = 2, ds_hold = 40, ds_wait = 0, ds_left = 0;
    always @(posedge clk) begin
        if (ds_mode == 2) begin
            px_busy <= 1'b1;
            ds_left <= 0;
            ds_wait <= 0;
        end else if (ds_mode == 1) begin
            px_busy <= 1'b0;
        end else if (px_valid) begin
            if (ds_delay <= 1) begin
                px_busy <= 1'b1;
                ds_left <= ds_hold;
            end else begin
                ds_wait <= ds_delay - 1;
            end
        end else if (ds_wait > 0) begin
            ds_wait <= ds_wait - 1;
            if (ds_wait == 1) begin
                px_busy <= 1'b1;
                ds_left <= ds_hold;
            end
        end else if (px_busy) begin
            if (ds_left <= 1) px_busy <= 1'b0;
            else ds_left <= ds_left - 1;
        end
    end

    int ds_left_b = 0;
    always @(posedge clk) begin
        if (px_valid_b) begin
            px_busy_b <= 1'b1;
            ds_left_b <= 3;
        end else if (px_busy_b) begin
            if (ds_left_b <= 1) px_busy_b <= 1'b0;
            else ds_left_b <= ds_left_b - 1;
        end
    end

    // Byte capture, sampled on the falling edge.
    int         cyc = 0;
    logic [7:0] cap[$];
    int         cap_cyc[$];
    logic [7:0] cap_b[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (px_valid) begin
            cap.push_back(px_value);
            cap_cyc.push_back(cyc);
        end
        if (px_valid_b) cap_b.push_back(px_value_b);
    end

    int         n_checks = 0, n_fail = 0;
    logic [7:0] model_store [16];
    logic [7:0] model_b     [8];
    logic [7:0] snap        [16];
    logic [7:0] exp_q[$];
    logic [7:0] first_exp[$];

    typedef struct {
        logic [3:0] col;
        logic [7:0] data;
        logic [2:0] bright;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_disp;
    } vec_t;
    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 8'hxx;
    endfunction

    // Frame as the protocol defines it, from the snapshot array.
    task automatic build_expected(input int cols, input logic [2:0] b);
        exp_q.delete();
        exp_q.push_back(8'h44);
        for (int i = 0; i < cols; i++) begin
            exp_q.push_back(8'hC0 + 8'(i));
            exp_q.push_back(snap[i]);
        end
        exp_q.push_back(8'h88 | {5'b0, b});
    endtask

    task automatic write_col(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_store[a] = d;
    endtask

    task automatic pulse_refresh(input logic [2:0] b);
        @(negedge clk);
        refresh = 1'b1; brightness = b;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    // Refresh into an idle DUT: the snapshot is the store right now.
    task automatic do_refresh(input logic [2:0] b);
        for (int i = 0; i < 16; i++) snap[i] = model_store[i];
        build_expected(16, b);
        pulse_refresh(b);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 16; i++) model_store[i] = 8'h00;
        for (int i = 0; i < 8; i++) model_b[i] = 8'h00;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int low = 0, n = 0;
        while (low < 10 && n < budget) begin
            @(negedge clk);
            n++;
            if (!frame_busy) low++; else low = 0;
        end
        checkOutput({name, " frame finished"}, 32'(low >= 10), 1);
    endtask

    task automatic wait_bytes(input int count, input int budget, input string name);
        int n = 0;
        while (cap.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " bytes seen"}, 32'(cap.size() >= count), 1);
    endtask

    task automatic check_frame(input string name);
        checkOutput({name, " length"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("%s byte %0d", name, i), cap_at(i), exp_q[i]);
    endtask

    task automatic applyStimulus(input vec_t v);
        write_col(v.col, v.data);
        cap.delete();
        do_refresh(v.bright);
        wait_quiet(1000, "table");
    endtask

    initial begin
        logic [7:0] one;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
        refresh = 1'b0; brightness = 3'd0;
        wr_en_b = 1'b0; wr_addr_b = 4'd0; wr_data_b = 8'h00;
        refresh_b = 1'b0; brightness_b = 3'd0;
        for (int i = 0; i < 16; i++) model_store[i] = 8'h00;
        for (int i = 0; i < 8; i++) model_b[i] = 8'h00;
        vecs[0] = '{4'd0,  8'h3C, 3'd0, 8'hC0, 8'h3C, 8'h88};
        vecs[1] = '{4'd7,  8'hFF, 3'd5, 8'hC7, 8'hFF, 8'h8D};
        vecs[2] = '{4'd9,  8'h00, 3'd2, 8'hC9, 8'h00, 8'h8A};
        vecs[3] = '{4'd15, 8'h5A, 3'd4, 8'hCF, 8'h5A, 8'h8C};

        repeat (3) @(negedge clk);
        checkOutput("reset frame_busy", frame_busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset px_valid", px_valid, 0);
        checkOutput("reset px_value", px_value, 0);
        checkOutput("reset frame_busy_b", frame_busy_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] walking-bit frame, brightness 7");
        ds_delay = 2; ds_hold = 40;
        one = 8'h01;
        for (int i = 0; i < 16; i++) write_col(4'(i), one << (i % 8));
        cap.delete();
        do_refresh(3'd7);
        wait_quiet(3000, "s1");
        check_frame("s1");
        checkOutput("s1 first byte", cap_at(0), 8'h44);
        checkOutput("s1 col15 data", cap_at(32), 8'h80);
        checkOutput("s1 display byte", cap_at(33), 8'h8F);
        checkOutput("s1 frame_busy low", frame_busy, 0);

        $display("[TB] refresh three times during a frame");
        cap.delete();
        do_refresh(3'd7);
        first_exp = exp_q;
        repeat (3) begin
            repeat (100) @(negedge clk);
            pulse_refresh(3'd7);
        end
        wait_quiet(6000, "s2");
        checkOutput("s2 two frames", cap.size(), 68);
        for (int i = 0; i < 68; i++)
            checkOutput($sformatf("s2 byte %0d", i), cap_at(i), first_exp[i % 34]);
        checkOutput("s2 err", err, 0);

        $display("[TB] column write during a frame");
        cap.delete();
        do_refresh(3'd7);
        wait_bytes(4, 500, "s3");
        write_col(4'd5, 8'hAA);
        wait_quiet(3000, "s3 old");
        check_frame("s3 old");
        cap.delete();
        do_refresh(3'd7);
        wait_quiet(3000, "s3 new");
        check_frame("s3 new");
        checkOutput("s3 addr C5", cap_at(11), 8'hC5);
        checkOutput("s3 data AA", cap_at(12), 8'hAA);

        $display("[TB] table vectors");
        ds_delay = 1; ds_hold = 2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d length", k), cap.size(), 34);
            checkOutput($sformatf("vec%0d addr", k), cap_at(1 + 2 * int'(vecs[k].col)), vecs[k].exp_addr);
            checkOutput($sformatf("vec%0d data", k), cap_at(2 + 2 * int'(vecs[k].col)), vecs[k].exp_data);
            checkOutput($sformatf("vec%0d disp", k), cap_at(33), vecs[k].exp_disp);
        end

        $display("[TB] randomized frames");
        for (int r = 0; r < 5; r++) begin
            ds_delay = int'($urandom_range(1, 2));
            ds_hold  = int'($urandom_range(1, 6));
            repeat (8) write_col(4'($urandom_range(0, 15)), 8'($urandom));
            cap.delete();
            do_refresh(3'($urandom_range(0, 7)));
            repeat (3) begin
                repeat ($urandom_range(5, 30)) @(negedge clk);
                write_col(4'($urandom_range(0, 15)), 8'($urandom));
            end
            wait_quiet(2000, $sformatf("rand%0d", r));
            check_frame($sformatf("rand%0d", r));
        end

        $display("[TB] downstream never acknowledges");
        ds_mode = 1;
        cap.delete(); cap_cyc.delete();
        do_refresh(3'd0);
        wait_bytes(2, 100, "s4");
        checkOutput("s4 first byte", cap_at(0), 8'h44);
        checkOutput("s4 reissued byte", cap_at(1), 8'h44);
        checkOutput("s4 reissue gap", (cap_cyc.size() >= 2) ? cap_cyc[1] - cap_cyc[0] : 0, 16);
        checkOutput("s4 err set", err, 1);
        ds_mode = 0; ds_delay = 1; ds_hold = 2;
        wait_quiet(2000, "s4 recover");
        checkOutput("s4 err sticky", err, 1);
        checkOutput("s4 last byte", (cap.size() > 0) ? cap[cap.size() - 1] : 8'hxx, 8'h88);
        do_reset();
        checkOutput("s4 err cleared", err, 0);

        $display("[TB] reset in mid frame with downstream still busy");
        ds_delay = 2; ds_hold = 10;
        for (int i = 0; i < 16; i++) write_col(4'(i), 8'(i * 3 + 1));
        cap.delete();
        do_refresh(3'd2);
        wait_bytes(11, 2000, "s5");
        begin
            int n = 0;
            while (!px_busy && n < 20) begin @(negedge clk); n++; end
        end
        checkOutput("s5 downstream busy", px_busy, 1);
        ds_mode = 2;
        do_reset();
        cap.delete();
        repeat (3) @(negedge clk);
        pulse_refresh(3'd5);
        repeat (17) @(negedge clk);
        checkOutput("s5 no strobe while busy", cap.size(), 0);
        checkOutput("s5 frame_busy low", frame_busy, 0);
        ds_mode = 0;
        for (int i = 0; i < 16; i++) snap[i] = 8'h00;
        build_expected(16, 3'd5);
        wait_quiet(3000, "s5 frame");
        check_frame("s5");

        $display("[TB] 8-column instance, out-of-range write");
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 8'hFF;
        @(negedge clk);
        wr_addr_b = 4'd3; wr_data_b = 8'h33; model_b[3] = 8'h33;
        @(negedge clk);
        wr_en_b = 1'b0;
        cap_b.delete();
        @(negedge clk); refresh_b = 1'b1; brightness_b = 3'd1;
        @(negedge clk); refresh_b = 1'b0;
        begin
            int low = 0, n = 0;
            while (low < 10 && n < 1000) begin
                @(negedge clk);
                n++;
                if (!frame_busy_b) low++; else low = 0;
            end
            checkOutput("s6 frame finished", 32'(low >= 10), 1);
        end
        for (int i = 0; i < 8; i++) snap[i] = model_b[i];
        build_expected(8, 3'd1);
        checkOutput("s6 length", cap_b.size(), 18);
        for (int i = 0; i < 18; i++)
            checkOutput($sformatf("s6 byte %0d", i), (i < cap_b.size()) ? cap_b[i] : 8'hxx, exp_q[i]);
        checkOutput("s6 err", err_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
